// File: rtl/lcd_hd44780_responder.sv
// HD44780 write-side responder: bus timing checker, command decoder and 80-byte DDRAM mirror.
// Define LCD_RESP_STRICT_EN to flag RS/DATA changes while EN is high.
module lcd_hd44780_responder #(
  parameter int unsigned BOOT_CYC   = 750000,
  parameter int unsigned BUSY_CYC   = 2150,
  parameter int unsigned CLEAR_CYC  = 76500,
  parameter int unsigned EN_MIN_CYC = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  LCD_DATA,
  input  logic        LCD_RS,
  input  logic        LCD_RW,
  input  logic        LCD_EN,
  input  logic [6:0]  i_rd_addr,
  output logic [7:0]  o_rd_data,
  output logic        o_busy,
  output logic [6:0]  o_ac,
  output logic        o_disp_on,
  output logic        o_cursor_on,
  output logic        o_blink_on,
  output logic        o_incr,
  output logic [15:0] o_wr_cnt,
  output logic        o_err_busy,
  output logic        o_err_short,
  output logic        o_err_rw,
  output logic        o_err_addr,
  output logic        o_err_unsup,
  output logic        o_err_setup
);

  typedef enum logic [1:0] {ST_FILL, ST_BOOT, ST_READY, ST_BUSY} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic        fill_boot_q;
  logic [6:0]  fill_idx_q;
  logic        en_q;
  logic [15:0] en_hi_q;
  logic [6:0]  ac_q;
  logic        disp_q, cursor_q, blink_q, incr_q;
  logic [15:0] wr_cnt_q;
  logic        err_busy_q, err_short_q, err_rw_q, err_addr_q, err_unsup_q;
  logic [7:0]  rd_data_q;
  logic [7:0]  ddram [0:79];

  // Cursor step inside the two 40-character line windows, wrapping line to line.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] r;
    if (up) r = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    else    r = (ac == 7'h40) ? 7'h27 : (ac == 7'h00) ? 7'h67 : ac - 7'd1;
    return r;
  endfunction

  function automatic logic [6:0] ac_idx(input logic [6:0] ac);
    return (ac < 7'h28) ? ac : ac - 7'd24;
  endfunction

  logic       en_rise, en_fall, en_ok, accept, addr_ok;
  logic       we;
  logic [6:0] wr_idx;
  logic [7:0] wr_data;

  assign en_rise = LCD_EN & ~en_q;
  assign en_fall = en_q & ~LCD_EN;
  assign en_ok   = (en_hi_q >= 16'(EN_MIN_CYC));
  assign accept  = en_fall && (state_q == ST_READY) && en_ok && !LCD_RW;
  assign addr_ok = (LCD_DATA[6:0] <= 7'h27) ||
                   ((LCD_DATA[6:0] >= 7'h40) && (LCD_DATA[6:0] <= 7'h67));

  // Fill and data writes never coincide: data is only accepted in READY.
  always_comb begin
    we      = 1'b0;
    wr_idx  = fill_idx_q;
    wr_data = 8'h20;
    if (state_q == ST_FILL) begin
      we = 1'b1;
    end else if (accept && LCD_RS) begin
      we      = 1'b1;
      wr_idx  = ac_idx(ac_q);
      wr_data = LCD_DATA;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we) ddram[wr_idx] <= wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)                  rd_data_q <= 8'h20;
    else if (i_rd_addr < 7'd80) rd_data_q <= ddram[i_rd_addr];
    else                        rd_data_q <= 8'h20;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FILL;
      cnt_q       <= 32'(BOOT_CYC);
      fill_boot_q <= 1'b1;
      fill_idx_q  <= 7'd0;
      en_q        <= 1'b0;
      en_hi_q     <= 16'd0;
      ac_q        <= 7'd0;
      disp_q      <= 1'b0;
      cursor_q    <= 1'b0;
      blink_q     <= 1'b0;
      incr_q      <= 1'b1;
      wr_cnt_q    <= 16'd0;
      err_busy_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_rw_q    <= 1'b0;
      err_addr_q  <= 1'b0;
      err_unsup_q <= 1'b0;
    end else begin
      err_busy_q  <= 1'b0;
      err_short_q <= 1'b0;
      err_rw_q    <= 1'b0;
      err_addr_q  <= 1'b0;
      err_unsup_q <= 1'b0;
      en_q        <= LCD_EN;

      // en_hi equals the number of sampled EN-high cycles of the current strobe.
      if (en_rise)                             en_hi_q <= 16'd1;
      else if (LCD_EN && en_hi_q != 16'hFFFF)  en_hi_q <= en_hi_q + 16'd1;

      case (state_q)
        ST_FILL: begin
          if (fill_idx_q == 7'd79) begin
            fill_idx_q <= 7'd0;
            if (cnt_q == 32'd0)   state_q <= ST_READY;
            else if (fill_boot_q) state_q <= ST_BOOT;
            else                  state_q <= ST_BUSY;
          end else begin
            fill_idx_q <= fill_idx_q + 7'd1;
          end
        end
        ST_BOOT, ST_BUSY: begin
          if (cnt_q <= 32'd1) state_q <= ST_READY;
          else                cnt_q   <= cnt_q - 32'd1;
        end
        default: ;
      endcase

      if (en_fall) begin
        if (state_q != ST_READY) begin
          err_busy_q <= 1'b1;
        end else if (!en_ok) begin
          err_short_q <= 1'b1;
        end else if (LCD_RW) begin
          err_rw_q <= 1'b1;
        end else begin
          state_q <= ST_BUSY;
          cnt_q   <= 32'(BUSY_CYC);
          if (LCD_RS) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
            ac_q     <= ac_step(ac_q, incr_q);
          end else begin
            casez (LCD_DATA)
              8'b1???????: begin
                if (addr_ok) ac_q <= LCD_DATA[6:0];
                else         err_addr_q <= 1'b1;
              end
              8'b0001????: begin
                if (!LCD_DATA[3]) ac_q <= ac_step(ac_q, LCD_DATA[2]);
                else              err_unsup_q <= 1'b1;
              end
              8'b00001???: begin
                disp_q   <= LCD_DATA[2];
                cursor_q <= LCD_DATA[1];
                blink_q  <= LCD_DATA[0];
              end
              8'b000001??: begin
                incr_q <= LCD_DATA[1];
                if (LCD_DATA[0]) err_unsup_q <= 1'b1;
              end
              8'b0000001?: begin
                ac_q  <= 7'd0;
                cnt_q <= 32'(CLEAR_CYC);
              end
              8'b00000001: begin
                // The 80 fill cycles count toward the clear window.
                ac_q        <= 7'd0;
                incr_q      <= 1'b1;
                state_q     <= ST_FILL;
                fill_idx_q  <= 7'd0;
                fill_boot_q <= 1'b0;
                cnt_q       <= 32'(CLEAR_CYC - 80);
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

`ifdef LCD_RESP_STRICT_EN
  logic [8:0] setup_ref_q;
  logic       setup_seen_q;
  logic       err_setup_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      setup_ref_q  <= 9'd0;
      setup_seen_q <= 1'b0;
      err_setup_q  <= 1'b0;
    end else begin
      err_setup_q <= 1'b0;
      if (en_rise) begin
        setup_ref_q  <= {LCD_RS, LCD_DATA};
        setup_seen_q <= 1'b0;
      end else if (LCD_EN && en_q && !setup_seen_q &&
                   ({LCD_RS, LCD_DATA} != setup_ref_q)) begin
        err_setup_q  <= 1'b1;
        setup_seen_q <= 1'b1;
      end
    end
  end

  assign o_err_setup = err_setup_q;
`else
  assign o_err_setup = 1'b0;
`endif

  assign o_rd_data   = rd_data_q;
  assign o_busy      = (state_q != ST_READY);
  assign o_ac        = ac_q;
  assign o_disp_on   = disp_q;
  assign o_cursor_on = cursor_q;
  assign o_blink_on  = blink_q;
  assign o_incr      = incr_q;
  assign o_wr_cnt    = wr_cnt_q;
  assign o_err_busy  = err_busy_q;
  assign o_err_short = err_short_q;
  assign o_err_rw    = err_rw_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_unsup = err_unsup_q;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Self-checking bench for lcd_hd44780_responder: command/data vector table plus
// hand-written timing sequences; mirror reads are checked through a scoreboard queue.
module tb_lcd_hd44780_responder;
  localparam int BOOT  = 200;
  localparam int BUSY  = 50;
  localparam int CLEAR = 300;
  localparam int ENMIN = 12;
`ifdef LCD_RESP_STRICT_EN
  localparam int EXP_SETUP = 1;
`else
  localparam int EXP_SETUP = 0;
`endif

  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_BUSY  = 6'b100000;
  localparam logic [5:0] E_SHORT = 6'b010000;
  localparam logic [5:0] E_RW    = 6'b001000;
  localparam logic [5:0] E_ADDR  = 6'b000100;
  localparam logic [5:0] E_UNSUP = 6'b000010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  LCD_DATA = 8'h00;
  logic        LCD_RS = 1'b0, LCD_RW = 1'b0, LCD_EN = 1'b0;
  logic [6:0]  rd_addr = 7'd0;
  logic [7:0]  rd_data;
  logic        busy, disp_on, cursor_on, blink_on, incr;
  logic [6:0]  ac;
  logic [15:0] wr_cnt;
  logic        err_busy, err_short, err_rw, err_addr, err_unsup, err_setup;

  lcd_hd44780_responder #(
    .BOOT_CYC(BOOT), .BUSY_CYC(BUSY), .CLEAR_CYC(CLEAR), .EN_MIN_CYC(ENMIN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .i_rd_addr(rd_addr), .o_rd_data(rd_data), .o_busy(busy), .o_ac(ac),
    .o_disp_on(disp_on), .o_cursor_on(cursor_on), .o_blink_on(blink_on), .o_incr(incr),
    .o_wr_cnt(wr_cnt), .o_err_busy(err_busy), .o_err_short(err_short), .o_err_rw(err_rw),
    .o_err_addr(err_addr), .o_err_unsup(err_unsup), .o_err_setup(err_setup)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int setup_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err_setup) setup_cnt <= setup_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] exp;
    int         due;
    logic [6:0] addr;
  } rd_exp_t;
  rd_exp_t rd_q[$];

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic       rw;
    int         hi;
    logic       pre;
    logic [5:0] err;
    logic [6:0] ac;
    logic [15:0] wr;
    logic [3:0] flg;
  } vec_t;
  vec_t vq[$];

  function automatic logic [5:0] errvec();
    return {err_busy, err_short, err_rw, err_addr, err_unsup, err_setup};
  endfunction

  function automatic logic [3:0] flags();
    return {disp_on, cursor_on, blink_on, incr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every read whose data is due at this negedge.
  task automatic sb_service();
    rd_exp_t e;
    while (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      e = rd_q.pop_front();
      chk($sformatf("rd[%0d]", e.addr), 32'(rd_data), 32'(e.exp));
    end
  endtask

  task automatic rd_push(input int addr, input logic [7:0] exp);
    rd_exp_t e;
    rd_addr = 7'(addr);
    e.exp = exp; e.due = cyc + 1; e.addr = 7'(addr);
    rd_q.push_back(e);
  endtask

  task automatic rd_issue(input int addr, input logic [7:0] exp);
    @(negedge clk);
    sb_service();
    rd_push(addr, exp);
  endtask

  task automatic rd_drain();
    @(negedge clk);
    sb_service();
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1; n++;
    end
    if (busy) begin
      n_checks++; n_errors++;
      $display("FAIL ready_timeout: got busy=1 expected busy=0");
    end
  endtask

  // Cycles from the last reset edge until o_busy drops.
  task automatic boot_len(output int n);
    n = 0;
    while (busy && n < 5000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  // One strobe with EN high for 'hi' sampled cycles. e1 = pulses after the
  // fall edge, e2 = one cycle later, blen = busy length from the fall edge.
  task automatic strobe(input logic rs, input logic [7:0] d, input logic rw, input int hi,
                        input logic meas, output logic [5:0] e1, output logic [5:0] e2,
                        output int blen);
    @(negedge clk);
    LCD_RS = rs; LCD_DATA = d; LCD_RW = rw; LCD_EN = 1'b1;
    repeat (hi) @(negedge clk);
    LCD_EN = 1'b0;
    @(posedge clk); #1;
    e1 = errvec();
    @(posedge clk); #1;
    e2 = errvec();
    blen = 0;
    if (meas) begin
      blen = 1;
      while (busy && blen < 5000) begin
        @(posedge clk); #1; blen++;
      end
    end
    LCD_RW = 1'b0;
  endtask

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input logic rw,
                              input int hi, input logic pre, input logic [5:0] err,
                              input logic [6:0] a, input logic [15:0] wr, input logic [3:0] flg);
    vec_t v;
    v.rs = rs; v.data = d; v.rw = rw; v.hi = hi; v.pre = pre;
    v.err = err; v.ac = a; v.wr = wr; v.flg = flg;
    return v;
  endfunction

  initial begin
    logic [5:0] e1, e2;
    int blen, n, s0;

    //          rs    data  rw  hi pre err      ac     wr  {disp,cur,blink,incr}
    vq.push_back(mk(1'b0, 8'h80, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd0, 4'b0001));
    vq.push_back(mk(1'b1, 8'h41, 1'b0, 20, 1'b1, E_NONE,  7'h01, 16'd1, 4'b0001));
    vq.push_back(mk(1'b0, 8'hA7, 1'b0, 20, 1'b1, E_NONE,  7'h27, 16'd1, 4'b0001));
    vq.push_back(mk(1'b1, 8'h42, 1'b0, 20, 1'b1, E_NONE,  7'h40, 16'd2, 4'b0001));
    vq.push_back(mk(1'b0, 8'hE8, 1'b0, 20, 1'b1, E_ADDR,  7'h40, 16'd2, 4'b0001));
    vq.push_back(mk(1'b1, 8'h43, 1'b0, 20, 1'b0, E_BUSY,  7'h40, 16'd2, 4'b0001));
    vq.push_back(mk(1'b1, 8'h43, 1'b0,  5, 1'b1, E_SHORT, 7'h40, 16'd2, 4'b0001));
    vq.push_back(mk(1'b1, 8'h43, 1'b0, 11, 1'b1, E_SHORT, 7'h40, 16'd2, 4'b0001));
    vq.push_back(mk(1'b1, 8'h44, 1'b0, 13, 1'b1, E_NONE,  7'h41, 16'd3, 4'b0001));
    vq.push_back(mk(1'b1, 8'h99, 1'b1, 20, 1'b1, E_RW,    7'h41, 16'd3, 4'b0001));
    vq.push_back(mk(1'b0, 8'h0F, 1'b0, 20, 1'b1, E_NONE,  7'h41, 16'd3, 4'b1111));
    vq.push_back(mk(1'b0, 8'h04, 1'b0, 20, 1'b1, E_NONE,  7'h41, 16'd3, 4'b1110));
    vq.push_back(mk(1'b1, 8'h45, 1'b0, 20, 1'b1, E_NONE,  7'h40, 16'd4, 4'b1110));
    vq.push_back(mk(1'b1, 8'h46, 1'b0, 20, 1'b1, E_NONE,  7'h27, 16'd5, 4'b1110));
    vq.push_back(mk(1'b0, 8'h07, 1'b0, 20, 1'b1, E_UNSUP, 7'h27, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h18, 1'b0, 20, 1'b1, E_UNSUP, 7'h27, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h14, 1'b0, 20, 1'b1, E_NONE,  7'h40, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h10, 1'b0, 20, 1'b1, E_NONE,  7'h27, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h80, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h10, 1'b0, 20, 1'b1, E_NONE,  7'h67, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'h14, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd5, 4'b1111));
    vq.push_back(mk(1'b0, 8'hE7, 1'b0, 20, 1'b1, E_NONE,  7'h67, 16'd5, 4'b1111));
    vq.push_back(mk(1'b1, 8'h47, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd6, 4'b1111));
    vq.push_back(mk(1'b0, 8'h08, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'h40, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'h38, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'h00, 1'b0, 20, 1'b1, E_NONE,  7'h00, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'hFF, 1'b0, 20, 1'b1, E_ADDR,  7'h00, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'hC0, 1'b0, 20, 1'b1, E_NONE,  7'h40, 16'd6, 4'b0001));
    vq.push_back(mk(1'b0, 8'hA8, 1'b0, 20, 1'b1, E_ADDR,  7'h40, 16'd6, 4'b0001));

    // Reset values and boot window.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ac", 32'(ac), 32'd0);
    chk("rst_flags", 32'(flags()), 32'b0001);
    chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h20);
    chk("rst_errs", 32'(errvec()), 32'd0);
    rst = 1'b0;
    boot_len(n);
    $display("boot: busy for %0d cycles", n);
    chk("boot_len", 32'(n), 32'(BOOT + 80));
    rd_issue(0, 8'h20); rd_issue(79, 8'h20); rd_issue(100, 8'h20);
    rd_drain();

    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].pre) wait_ready();
      strobe(vq[i].rs, vq[i].data, vq[i].rw, vq[i].hi, 1'b0, e1, e2, blen);
      $display("vec %0d: rs=%0b data=0x%02h rw=%0b hi=%0d err=%06b ac=0x%02h wr=%0d",
               i, vq[i].rs, vq[i].data, vq[i].rw, vq[i].hi, e1, ac, wr_cnt);
      chk($sformatf("vec%0d_err", i), 32'(e1), 32'(vq[i].err));
      chk($sformatf("vec%0d_err_clr", i), 32'(e2), 32'd0);
      chk($sformatf("vec%0d_ac", i), 32'(ac), 32'(vq[i].ac));
      chk($sformatf("vec%0d_wr_cnt", i), 32'(wr_cnt), 32'(vq[i].wr));
      chk($sformatf("vec%0d_flags", i), 32'(flags()), 32'(vq[i].flg));
    end

    rd_issue(0, 8'h41); rd_issue(1, 8'h20); rd_issue(39, 8'h42); rd_issue(40, 8'h46);
    rd_issue(41, 8'h45); rd_issue(79, 8'h47); rd_issue(80, 8'h20); rd_issue(127, 8'h20);
    rd_drain();

    // Busy window lengths for a normal command and for home.
    wait_ready();
    strobe(1'b0, 8'h85, 1'b0, 20, 1'b1, e1, e2, blen);
    $display("cmd 0x85: busy %0d cycles ac=0x%02h", blen, ac);
    chk("busy_len", 32'(blen), 32'(BUSY));
    chk("set_addr_ac", 32'(ac), 32'h05);
    strobe(1'b0, 8'h02, 1'b0, 20, 1'b1, e1, e2, blen);
    $display("home: busy %0d cycles ac=0x%02h", blen, ac);
    chk("home_len", 32'(blen), 32'(CLEAR));
    chk("home_ac", 32'(ac), 32'h00);

    // Same-cycle read and write of index 0 returns the old byte first.
    @(negedge clk);
    LCD_RS = 1'b1; LCD_DATA = 8'h5A; LCD_EN = 1'b1;
    repeat (20) @(negedge clk);
    LCD_EN = 1'b0;
    rd_push(0, 8'h41);
    @(negedge clk); sb_service(); rd_push(0, 8'h5A);
    @(negedge clk); sb_service();
    $display("rw collision: data 0x5A to index 0 ac=0x%02h wr=%0d", ac, wr_cnt);
    chk("coll_ac", 32'(ac), 32'h01);
    chk("coll_wr_cnt", 32'(wr_cnt), 32'd7);

    // Clear restores the fill pattern and the entry mode.
    wait_ready();
    strobe(1'b0, 8'h04, 1'b0, 20, 1'b1, e1, e2, blen);
    chk("pre_clear_incr", 32'(incr), 32'd0);
    strobe(1'b0, 8'h01, 1'b0, 20, 1'b1, e1, e2, blen);
    $display("clear: busy %0d cycles ac=0x%02h", blen, ac);
    chk("clear_len", 32'(blen), 32'(CLEAR));
    chk("clear_ac", 32'(ac), 32'h00);
    chk("clear_incr", 32'(incr), 32'd1);
    chk("clear_wr_cnt", 32'(wr_cnt), 32'd7);
    for (int a = 0; a < 80; a++) rd_issue(a, 8'h20);
    rd_drain();

    // DATA changes twice while EN is high; the final value is the command.
    wait_ready();
    s0 = setup_cnt;
    @(negedge clk);
    LCD_RS = 1'b0; LCD_DATA = 8'h80; LCD_EN = 1'b1;
    repeat (5) @(negedge clk);
    LCD_DATA = 8'h81;
    repeat (5) @(negedge clk);
    LCD_DATA = 8'h83;
    repeat (10) @(negedge clk);
    LCD_EN = 1'b0;
    repeat (3) @(negedge clk);
    $display("setup strobe: pulses=%0d ac=0x%02h", setup_cnt - s0, ac);
    chk("setup_pulses", 32'(setup_cnt - s0), 32'(EXP_SETUP));
    chk("setup_ac", 32'(ac), 32'h03);

    // Reset in the middle of a busy window restarts fill and boot.
    wait_ready();
    strobe(1'b1, 8'h77, 1'b0, 20, 1'b0, e1, e2, blen);
    chk("pre_rst_wr_cnt", 32'(wr_cnt), 32'd8);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ac", 32'(ac), 32'd0);
    chk("midrst_wr_cnt", 32'(wr_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    boot_len(n);
    $display("mid reset: busy for %0d cycles", n);
    chk("midrst_boot_len", 32'(n), 32'(BOOT + 80));
    rd_issue(3, 8'h20);
    rd_drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable model of the HD44780 character-LCD side of the parallel write bus driven by the board LCD controller.
- Samples DATA/RS/EN/RW and decodes commands into an 80-byte DDRAM plus control state.
- Enforces boot, busy and enable-width timing and reports protocol violations as pulses.
- Used as an on-chip bus checker and as a DDRAM mirror readable by display/debug logic.

Parameters:
- BOOT_CYC, 750000, power-on window after reset in which writes are errors (15 ms at 50 MHz).
- BUSY_CYC, 2150, busy window after a normal command or data write (43 us).
- CLEAR_CYC, 76500, busy window after clear/home (1.53 ms); must be >= 80.
- EN_MIN_CYC, 12, minimum EN high width in cycles (230 ns).

Ports:
- i_clk  in  1  system clock; all inputs sampled on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- LCD_DATA  in  8  bus data.
- LCD_RS  in  1  0 = command, 1 = data.
- LCD_RW  in  1  must be 0; reads are unsupported.
- LCD_EN  in  1  enable strobe; the transfer is latched on its falling edge.
- i_rd_addr  in  7  DDRAM index 0..79 for the mirror read.
- o_rd_data  out  8  DDRAM byte; 1-cycle latency; 0x20 when i_rd_addr >= 80.
- o_busy  out  1  high in BOOT, FILL and BUSY.
- o_ac  out  7  address counter, HD44780 encoding.
- o_disp_on, o_cursor_on, o_blink_on, o_incr  out  1 each  display-control and entry-mode state.
- o_wr_cnt  out  16  accepted data writes; wraps at 0xFFFF -> 0.
- o_err_busy, o_err_short, o_err_rw, o_err_addr, o_err_unsup, o_err_setup  out  1 each  single-cycle error pulses.

Behaviour:
- Reset values: all error pulses 0, o_ac = 0, o_incr = 1, o_disp_on/cursor/blink = 0, o_wr_cnt = 0, o_busy = 1, o_rd_data = 0x20.
- Reset enters FILL then BOOT. Reset mid-operation aborts everything and restarts the fill.
- Edge detect: en_q is a registered copy of LCD_EN. A fall is en_q=1 and LCD_EN=0. DATA/RS/RW are used from the fall cycle.
- en_hi counter, saturating: counts cycles with EN high, cleared at each rise.
- On a fall, checks run in this priority order; the first failing check pulses its error and the transfer is dropped:
  - 1. State is not READY -> o_err_busy.
  - 2. en_hi < EN_MIN_CYC -> o_err_short.
  - 3. RW = 1 -> o_err_rw.
- States:
  - FILL: writes 0x20 to indices 0..79, one per cycle (80 cycles). Then goes to BOOT after reset, or BUSY after a clear.
  - BOOT: counts BOOT_CYC, then READY.
  - READY: accepts transfers.
  - BUSY: counts down the loaded window, then READY. The count loads on the accept cycle; READY is reached exactly N cycles later.
- Data write (RS = 1):
  - DDRAM[idx(AC)] <= DATA; o_wr_cnt++.
  - AC steps by I/D with wrap 0x27 <-> 0x40 and 0x67 <-> 0x00.
  - Loads BUSY_CYC.
- Command decode (RS = 0) by highest set bit:
  - 1aaaaaaa: set DDRAM address. a in 0x00-0x27 or 0x40-0x67 -> AC = a. Otherwise AC is unchanged and o_err_addr pulses.
  - 01xxxxxx: CGRAM address; no effect.
  - 001xxxxx: function set; no effect.
  - 0001 S/C R/L xx: S/C = 0 moves the cursor, AC +/- 1 with wrap. S/C = 1 pulses o_err_unsup and AC is unchanged.
  - 00001DCB: sets disp/cursor/blink.
  - 000001 I/D S: sets o_incr = I/D. S = 1 also pulses o_err_unsup.
  - 0000001x: home. AC = 0; loads CLEAR_CYC.
  - 00000001: clear. AC = 0, o_incr = 1; enters FILL with the counter preloaded to CLEAR_CYC - 80.
  - 00000000: no-op.
  - All accepted commands except home and clear load BUSY_CYC, including commands that raise o_err_addr or o_err_unsup.
- idx mapping: AC < 0x28 -> AC; otherwise AC - 0x40 + 40.
- Mirror read port is independent of the write path. A same-cycle read and write to the same index returns the old data.

Optional Feature:
- Macro LCD_RESP_STRICT_EN.
- Defined: while EN is high, any change of RS or DATA from its value at the rise cycle pulses o_err_setup once per strobe. The transfer is still evaluated normally.
- Undefined: o_err_setup is tied to 0 and no comparison logic is built.

Test Plan:
- Reset, then wait BOOT_CYC + 80 cycles -> o_busy falls. Reading indices 0, 79, 100 -> 0x20 each.
- Command 0x80, then data 0x41 with 20-cycle EN strobes, gaps > BUSY_CYC -> DDRAM[0] = 0x41, o_ac = 0x01, o_wr_cnt = 1.
- Command 0xA7 (AC 0x27), then data 0x42 -> DDRAM[39] = 0x42, o_ac = 0x40. Command 0xE8 -> o_err_addr pulse, o_ac stays 0x40.
- Data strobe 100 cycles after an accepted write -> o_err_busy pulse, o_wr_cnt unchanged. Strobe with EN high 5 cycles -> o_err_short pulse.
- Clear 0x01 after writes -> o_busy high exactly CLEAR_CYC cycles, all 80 bytes 0x20, o_ac = 0.
- Strict build: flip DATA mid-strobe -> one o_err_setup pulse. Non-strict build: no pulse.
